// File: rtl/judge_pkg.sv
// Shared definitions for the rhythm-game judge, score and arrow generator blocks:
// game state codes, arrow codes, the arrow-to-button mask table and the judge FSM encoding.
package judge_pkg;

  localparam int CNT_W = 25;

  typedef enum logic [1:0] {
    GS_GAME  = 2'd0,
    GS_PAUSE = 2'd1,
    GS_RESET = 2'd2
  } game_state_e;

  localparam logic [4:0] ARROW_UP          = 5'd10;
  localparam logic [4:0] ARROW_DOWN        = 5'd11;
  localparam logic [4:0] ARROW_LEFT        = 5'd12;
  localparam logic [4:0] ARROW_RIGHT       = 5'd13;
  localparam logic [4:0] ARROW_UP_DOWN     = 5'd14;
  localparam logic [4:0] ARROW_UP_LEFT     = 5'd15;
  localparam logic [4:0] ARROW_UP_RIGHT    = 5'd16;
  localparam logic [4:0] ARROW_DOWN_LEFT   = 5'd17;
  localparam logic [4:0] ARROW_DOWN_RIGHT  = 5'd18;
  localparam logic [4:0] ARROW_LEFT_RIGHT  = 5'd19;
  localparam logic [4:0] ARROW_NONE        = 5'd20;

  typedef enum logic [2:0] {
    J_IDLE   = 3'd0,
    J_WINDOW = 3'd1,
    J_CHORD  = 3'd2,
    J_PULSE  = 3'd3,
    J_GAP    = 3'd4
  } judge_state_e;

  // Mask bit order is {up, down, left, right}; unknown codes behave like ARROW_NONE.
  function automatic logic [3:0] arrow_mask(input logic [4:0] code);
    case (code)
      ARROW_UP:         arrow_mask = 4'b1000;
      ARROW_DOWN:       arrow_mask = 4'b0100;
      ARROW_LEFT:       arrow_mask = 4'b0010;
      ARROW_RIGHT:      arrow_mask = 4'b0001;
      ARROW_UP_DOWN:    arrow_mask = 4'b1100;
      ARROW_UP_LEFT:    arrow_mask = 4'b1010;
      ARROW_UP_RIGHT:   arrow_mask = 4'b1001;
      ARROW_DOWN_LEFT:  arrow_mask = 4'b0110;
      ARROW_DOWN_RIGHT: arrow_mask = 4'b0101;
      ARROW_LEFT_RIGHT: arrow_mask = 4'b0011;
      ARROW_NONE:       arrow_mask = 4'b0000;
      default:          arrow_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/judge_btn_sync.sv
// One button input: two-flop synchronizer into the clk domain followed by a
// rising-edge detector, so a held button yields a single one-cycle press.
module judge_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/hit_judge.sv
// Judges button chords against the current target arrow and emits separated verdict pulses.
// Define JUDGE_TIMEOUT_MISS_EN to turn an expired window with no press into an incorrectHit.
module hit_judge #(
  parameter int WINDOW_CYCLES = 25000000,
  parameter int CHORD_CYCLES  = 1000000,
  parameter int PULSE_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [4:0] arrow_code,
  input  logic       arrow_valid,
  output logic       judge_ready,
  output logic       correctHit,
  output logic       incorrectHit,
  output logic [3:0] press_mask
);

  import judge_pkg::*;

  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHORD_LAST = CNT_W'(CHORD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic             syncClear;
  logic             paused;
  logic [3:0]       pressEdges;
  logic [3:0]       liveEdges;
  logic [3:0]       merged;

  judge_state_e     fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       acc_q, acc_d;
  logic [3:0]       target_q, target_d;
  logic             verdict_q, verdict_d;
  logic [3:0]       mask_q, mask_d;

  assign syncClear = rst | (state == GS_RESET);
  assign paused    = (state == GS_PAUSE);

  judge_btn_sync u_sync_up    (.clk(clk), .rst(syncClear), .btn_i(btn_up),    .edge_o(pressEdges[3]));
  judge_btn_sync u_sync_down  (.clk(clk), .rst(syncClear), .btn_i(btn_down),  .edge_o(pressEdges[2]));
  judge_btn_sync u_sync_left  (.clk(clk), .rst(syncClear), .btn_i(btn_left),  .edge_o(pressEdges[1]));
  judge_btn_sync u_sync_right (.clk(clk), .rst(syncClear), .btn_i(btn_right), .edge_o(pressEdges[0]));

  // Presses seen while paused are dropped, not deferred.
  assign liveEdges = paused ? 4'b0000 : pressEdges;
  assign merged    = acc_q | liveEdges;

  always_ff @(posedge clk) begin
    if (syncClear) begin
      fsm_q     <= J_IDLE;
      cnt_q     <= '0;
      acc_q     <= 4'b0000;
      target_q  <= 4'b0000;
      verdict_q <= 1'b0;
      mask_q    <= 4'b0000;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      target_q  <= target_d;
      verdict_q <= verdict_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    target_d  = target_q;
    verdict_d = verdict_q;
    mask_d    = mask_q;
    if (!paused) begin
      case (fsm_q)
        J_IDLE: begin
          if (arrow_valid) begin
            target_d = arrow_mask(arrow_code);
            acc_d    = 4'b0000;
            cnt_d    = '0;
            fsm_d    = J_WINDOW;
          end
        end
        J_WINDOW: begin
          // The cycle of the first press is already the first chord cycle.
          if (|liveEdges) begin
            acc_d = merged;
            cnt_d = CNT_W'(1);
            fsm_d = J_CHORD;
          end else if (cnt_q == WIN_LAST) begin
            cnt_d = '0;
`ifdef JUDGE_TIMEOUT_MISS_EN
            if (target_q != 4'b0000) begin
              verdict_d = 1'b0;
              mask_d    = 4'b0000;
              fsm_d     = J_PULSE;
            end else begin
              fsm_d = J_IDLE;
            end
`else
            fsm_d = J_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        J_CHORD: begin
          acc_d = merged;
          if (cnt_q == CHORD_LAST) begin
            verdict_d = (merged == target_q);
            mask_d    = merged;
            cnt_d     = '0;
            fsm_d     = J_PULSE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        J_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_d = '0;
            fsm_d = J_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        J_GAP: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_d = '0;
            fsm_d = J_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
          fsm_d = J_IDLE;
        end
      endcase
    end
  end

  assign judge_ready  = (fsm_q == J_IDLE);
  assign correctHit   = (fsm_q == J_PULSE) &  verdict_q;
  assign incorrectHit = (fsm_q == J_PULSE) & ~verdict_q;
  assign press_mask   = mask_q;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed corner trials plus randomized trials
// scored against a transaction-level model of the judging rules.
module tb_hit_judge;

   import judge_pkg::*;

   localparam int WIN   = 20;
   localparam int CHORD = 4;
   localparam int PULSE = 4;
   localparam int TLEN  = 60;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state;
   logic       btnUp, btnDown, btnLeft, btnRight;
   logic [4:0] arrowCode;
   logic       arrowValid;
   logic       judgeReady, correctHit, incorrectHit;
   logic [3:0] pressMask;

   int checks = 0;
   int passes = 0;
   logic [3:0] lastMask = 4'b0000;

   // Required masks for codes 10..20, bit order {up,down,left,right}.
   logic [3:0] maskTable [0:10] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100,
                                    4'b1010, 4'b1001, 4'b0110, 4'b0101, 4'b0011, 4'b0000};

   always #5 clk = ~clk;

   hit_judge #(.WINDOW_CYCLES(WIN), .CHORD_CYCLES(CHORD), .PULSE_CYCLES(PULSE)) dut (
      .clk(clk), .rst(rst), .state(state),
      .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
      .arrow_code(arrowCode), .arrow_valid(arrowValid),
      .judge_ready(judgeReady), .correctHit(correctHit), .incorrectHit(incorrectHit),
      .press_mask(pressMask)
   );

   // Single point of comparison: counts every check, reports any mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
   endtask

   function automatic logic [3:0] refTarget(input logic [4:0] code);
      if (code < 5'd10 || code > 5'd20) return 4'b0000;
      return maskTable[int'(code) - 10];
   endfunction

   task automatic setButtons(input logic [3:0] m);
      {btnUp, btnDown, btnLeft, btnRight} = m;
   endtask

   // Advance one clock and leave the bench 1ns past the edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1; state = 2'(GS_GAME); arrowValid = 1'b0; arrowCode = 5'd20;
      setButtons(4'b0000);
      tick(); tick();
      rst = 1'b0;
      lastMask = 4'b0000;
   endtask

   // One judged arrow: drives a per-cycle schedule, then scores what came out.
   // p is the cycle the first press group goes high, m2 rises d cycles later.
   task automatic applyStimulus(input string name, input logic [4:0] code, input bit doPress,
                                input int p, input logic [3:0] m1, input int d,
                                input logic [3:0] m2, input logic [3:0] preHeld,
                                input int pauseStart, input int pauseLen, input bit extraValid);
      logic [3:0] lvl [TLEN];
      bit         pz  [TLEN];
      bit         landed;
      logic [3:0] acc, tgt, expMask;
      int         expCorr, expInc;
      int         cc, ic, cr, ir, overlap, freezeErr;
      logic       prevC, prevI, prevR;
      logic [3:0] prevM;

      for (int t = 0; t < TLEN; t++) begin
         lvl[t] = (t < 5) ? preHeld : 4'b0000;
         pz[t]  = (pauseLen > 0) && (t >= pauseStart) && (t < pauseStart + pauseLen);
         if (doPress && t >= p && t < p + 8) lvl[t] |= m1;
         if (doPress && t >= p + d && t < p + d + 8) lvl[t] |= m2;
      end

      // A held button before the arrow must not count as a press.
      setButtons(preHeld);
      for (int i = 0; i < 4; i++) tick();

      // Two synchronizer flops sit between the pin and the edge detector.
      landed = doPress && (p <= WIN - 2);
      tgt = refTarget(code);
      acc = m1 | ((d <= CHORD - 1) ? m2 : 4'b0000);
      expCorr = 0; expInc = 0; expMask = lastMask;
      if (landed) begin
         expMask = acc;
         if (acc == tgt) expCorr = PULSE; else expInc = PULSE;
      end else begin
`ifdef JUDGE_TIMEOUT_MISS_EN
         if (tgt != 4'b0000) begin
            expInc = PULSE;
            expMask = 4'b0000;
         end
`endif
      end

      cc = 0; ic = 0; cr = 0; ir = 0; overlap = 0; freezeErr = 0;
      prevC = correctHit; prevI = incorrectHit; prevR = judgeReady; prevM = pressMask;
      for (int t = 0; t < TLEN; t++) begin
         setButtons(lvl[t]);
         state = pz[t] ? 2'(GS_PAUSE) : 2'(GS_GAME);
         arrowValid = (t == 0) || (extraValid && landed && t == p + 2);
         arrowCode = (t == 0) ? code : 5'(code + 5'd3);
         tick();
         if (t == 0) checkOutput({name, "_ready_low"}, int'(judgeReady), 0);
         if (pz[t]) begin
            if (correctHit !== prevC || incorrectHit !== prevI ||
                judgeReady !== prevR || pressMask !== prevM) freezeErr++;
         end else begin
            if (correctHit) cc++;
            if (incorrectHit) ic++;
         end
         if (correctHit && incorrectHit) overlap++;
         if (correctHit && !prevC) cr++;
         if (incorrectHit && !prevI) ir++;
         prevC = correctHit; prevI = incorrectHit; prevR = judgeReady; prevM = pressMask;
      end
      arrowValid = 1'b0;

      checkOutput({name, "_corr_cycles"}, cc, expCorr);
      checkOutput({name, "_inc_cycles"}, ic, expInc);
      checkOutput({name, "_corr_pulses"}, cr, (expCorr > 0) ? 1 : 0);
      checkOutput({name, "_inc_pulses"}, ir, (expInc > 0) ? 1 : 0);
      checkOutput({name, "_overlap"}, overlap, 0);
      checkOutput({name, "_press_mask"}, int'(pressMask), int'(expMask));
      checkOutput({name, "_ready_end"}, int'(judgeReady), 1);
      if (pauseLen > 0) checkOutput({name, "_freeze"}, freezeErr, 0);
      lastMask = expMask;
   endtask

   // Start a correct chord, then reset while the pulse is high.
   task automatic resetMidPulse(input string name, input bit viaState);
      bit seen;
      state = 2'(GS_GAME);
      arrowCode = 5'd16; arrowValid = 1'b1;
      tick();
      arrowValid = 1'b0;
      tick();
      setButtons(4'b1001);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (correctHit) seen = 1'b1;
      end
      checkOutput({name, "_pulse_seen"}, int'(seen), 1);
      checkOutput({name, "_mask_before"}, int'(pressMask), 9);
      if (viaState) state = 2'(GS_RESET); else rst = 1'b1;
      tick();
      checkOutput({name, "_corr_cut"}, int'(correctHit), 0);
      checkOutput({name, "_inc_cut"}, int'(incorrectHit), 0);
      checkOutput({name, "_ready"}, int'(judgeReady), 1);
      checkOutput({name, "_mask_clr"}, int'(pressMask), 0);
      rst = 1'b0; state = 2'(GS_GAME);
      setButtons(4'b0000);
      for (int i = 0; i < 4; i++) tick();
      lastMask = 4'b0000;
   endtask

   initial begin
      logic [4:0] code;
      logic [3:0] m1, m2, pre;
      bit doPress, xv;
      int p, d, ps, pl;

      doReset();
      checkOutput("rst_ready", int'(judgeReady), 1);
      checkOutput("rst_corr", int'(correctHit), 0);
      checkOutput("rst_inc", int'(incorrectHit), 0);
      checkOutput("rst_mask", int'(pressMask), 0);

      applyStimulus("up_right", 5'd16, 1, 3, 4'b1001, 0, 4'b0000, 4'b0000, 0, 0, 0);
      applyStimulus("up_only", 5'd14, 1, 4, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 0);
      applyStimulus("no_press", 5'd12, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
      applyStimulus("none_left", 5'd20, 1, 5, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0, 0);
      applyStimulus("none_quiet", 5'd20, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
      applyStimulus("pause_chord", 5'd10, 1, 3, 4'b1000, 0, 4'b0000, 4'b0000, 6, 10, 0);
      applyStimulus("win_last", 5'd13, 1, WIN - 2, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0);
      applyStimulus("win_late", 5'd13, 1, WIN - 1, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0);
      applyStimulus("chord_in", 5'd16, 1, 3, 4'b1000, CHORD - 1, 4'b0001, 4'b0000, 0, 0, 0);
      applyStimulus("chord_out", 5'd16, 1, 3, 4'b1000, CHORD, 4'b0001, 4'b0000, 0, 0, 0);
      applyStimulus("held_up", 5'd10, 1, 8, 4'b1000, 0, 4'b0000, 4'b1000, 0, 0, 1);
      applyStimulus("code_oor", 5'd27, 1, 2, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 0);
      resetMidPulse("rst_pulse", 0);
      resetMidPulse("state_rst", 1);

      for (int n = 0; n < 40; n++) begin
         code = 5'($urandom_range(8, 23));
         doPress = ($urandom_range(0, 4) != 0);
         pre = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         p = (pre != 0) ? $urandom_range(7, WIN - 1) : $urandom_range(1, WIN - 1);
         m1 = 4'($urandom_range(1, 15));
         if ($urandom_range(0, 1) == 1 && refTarget(code) != 4'b0000) m1 = refTarget(code);
         m2 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
         d = $urandom_range(0, CHORD + 1);
         ps = 0; pl = 0;
         if (m2 == 4'b0000 && $urandom_range(0, 2) == 0) begin
            ps = doPress ? p + 3 + $urandom_range(0, 9) : $urandom_range(2, 15);
            pl = $urandom_range(1, 10);
         end
         xv = ($urandom_range(0, 1) == 1);
         applyStimulus($sformatf("rnd%0d", n), code, doPress, p, m1, d, m2, pre, ps, pl, xv);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
